// File: rtl/onchip_write_master_output.sv
// Avalon-MM write master: buffers PE result words in a small FIFO and
// writes them to consecutive on-chip word addresses starting at a job base.
module onchip_write_master_output #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [ADDR_W-1:0]   addr_write,
   output logic [DATA_W-1:0]   data_write,
   output logic [DATA_W/8-1:0] byteenable,
   output logic                write,
   output logic                chipselect,
   input  logic                wait_request,
   input  logic [ADDR_W-1:0]   addr_base,
   input  logic [ADDR_W:0]     write_len,
   input  logic                start,
   output logic                busy,
   output logic                done,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                data_in_valid,
   output logic                data_in_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W:0]    fifo_cnt_q, fifo_cnt_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_write_q, addr_write_d;
   logic [DATA_W-1:0] data_write_q, data_write_d;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic reload;
   logic xfer_done;

   assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
   assign fifo_empty = (fifo_cnt_q == '0);

   // Ready ignores a same-cycle pop, so a full FIFO never bypasses.
   assign data_in_ready = (state_q == ST_RUN) && !fifo_full && (acc_cnt_q < len_q);
   assign push          = data_in_valid && data_in_ready;
   assign reload        = !write_q || !wait_request;
   assign pop           = reload && !fifo_empty;
   assign xfer_done     = write_q && !wait_request;

   assign write      = write_q;
   assign chipselect = write_q;
   assign addr_write = addr_write_q;
   assign data_write = data_write_q;
   assign byteenable = '1;
   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);

   // FIFO storage; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wptr_q] <= data_in;
      end
   end

   // Next-state, FIFO bookkeeping, output register reload and job counters.
   always_comb begin
      state_d      = state_q;
      addr_cnt_d   = addr_cnt_q;
      len_d        = len_q;
      acc_cnt_d    = acc_cnt_q;
      wr_cnt_d     = wr_cnt_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      fifo_cnt_d   = fifo_cnt_q;
      write_d      = write_q;
      addr_write_d = addr_write_q;
      data_write_d = data_write_q;

      if (push) begin
         wptr_d    = wptr_q + PTR_W'(1);
         acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end

      if (pop) begin
         rptr_d = rptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + (PTR_W+1)'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - (PTR_W+1)'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase

      if (reload) begin
         if (!fifo_empty) begin
            write_d      = 1'b1;
            data_write_d = fifo_mem[rptr_q];
            addr_write_d = addr_cnt_q;
            addr_cnt_d   = addr_cnt_q + ADDR_W'(1);
         end else begin
            write_d = 1'b0;
         end
      end

      if (xfer_done) begin
         wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_cnt_d = addr_base;
               len_d      = write_len;
               acc_cnt_d  = '0;
               wr_cnt_d   = '0;
               state_d    = (write_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (xfer_done && ((wr_cnt_q + CNT_W'(1)) == len_q)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters, FIFO pointers and the Avalon output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_cnt_q   <= '0;
         len_q        <= '0;
         acc_cnt_q    <= '0;
         wr_cnt_q     <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         fifo_cnt_q   <= '0;
         write_q      <= 1'b0;
         addr_write_q <= '0;
         data_write_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_cnt_q   <= addr_cnt_d;
         len_q        <= len_d;
         acc_cnt_q    <= acc_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
         write_q      <= write_d;
         addr_write_q <= addr_write_d;
         data_write_q <= data_write_d;
      end
   end

endmodule
